// File: rtl/bus_arbiter_rr_n.sv
// bus_arbiter_rr_n
//   N-requester round-robin arbiter in front of the single-port cache front-end.
//   Forwards one granted request per accepted transfer. Tracks outstanding reads
//   in an ID FIFO and routes each in-order cache read response back to its issuer.
//   Adds grant locking, FIFO-full read back-pressure and orphan-response detection.
// Ports
//   clk_i, arst_i              clock, synchronous active-high reset
//   req_valid/addr/wdata/wstrb per-lane request (flattened, wstrb==0 means read)
//   req_ready                  one-hot accept for the granted lane
//   rsp_rdata/rsp_rvalid       registered per-lane read response
//   cache_valid/addr/wdata/wstrb/ready  request channel to the cache
//   cache_rdata/cache_rvalid   in-order read data from the cache
//   rd_pending                 outstanding read count
//   err_orphan                 sticky: read data arrived with nothing outstanding
module bus_arbiter_rr_n #(
  parameter int N_REQ      = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STRB_W     = DATA_W / 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*ADDR_W-1:0]      req_addr,
  input  logic [N_REQ*DATA_W-1:0]      req_wdata,
  input  logic [N_REQ*STRB_W-1:0]      req_wstrb,
  output logic [N_REQ-1:0]             req_ready,
  output logic [N_REQ*DATA_W-1:0]      rsp_rdata,
  output logic [N_REQ-1:0]             rsp_rvalid,
  output logic                         cache_valid,
  output logic [ADDR_W-1:0]            cache_addr,
  output logic [DATA_W-1:0]            cache_wdata,
  output logic [STRB_W-1:0]            cache_wstrb,
  input  logic                         cache_ready,
  input  logic [DATA_W-1:0]            cache_rdata,
  input  logic                         cache_rvalid,
  output logic [$clog2(FIFO_DEPTH):0]  rd_pending,
  output logic                         err_orphan
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [ID_W-1:0]          r_last_grant;
  logic [ID_W-1:0]          r_lock_id;
  logic                     r_lock;
  logic [ID_W-1:0]          r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [PTR_W:0]           r_count;
  logic [N_REQ-1:0]         r_rsp_rvalid;
  logic [N_REQ*DATA_W-1:0]  r_rsp_rdata;
  logic                     r_err_orphan;

  logic                     w_hi_vld, w_lo_vld;
  logic [ID_W-1:0]          w_hi_id, w_lo_id;
  logic [ID_W-1:0]          w_grant_id;
  logic                     w_grant_vld;
  logic                     w_sel_valid;
  logic [ADDR_W-1:0]        w_sel_addr;
  logic [DATA_W-1:0]        w_sel_wdata;
  logic [STRB_W-1:0]        w_sel_wstrb;
  logic                     w_is_read;
  logic                     w_blocked;
  logic                     w_xfer;
  logic                     w_push;
  logic                     w_pop;

  // Rotating priority split into two ascending scans: lanes above last_grant
  // win first, otherwise the lowest valid lane at or below it (the wrap part).
  always_comb begin
    w_hi_vld = 1'b0;
    w_hi_id  = '0;
    w_lo_vld = 1'b0;
    w_lo_id  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && (ID_W'(i) > r_last_grant) && !w_hi_vld) begin
        w_hi_vld = 1'b1;
        w_hi_id  = ID_W'(i);
      end
      if (req_valid[i] && (ID_W'(i) <= r_last_grant) && !w_lo_vld) begin
        w_lo_vld = 1'b1;
        w_lo_id  = ID_W'(i);
      end
    end
  end

  assign w_grant_id = r_lock ? r_lock_id : (w_hi_vld ? w_hi_id : w_lo_id);

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wstrb = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_grant_id == ID_W'(i)) begin
        w_sel_valid = req_valid[i];
        w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        w_sel_wstrb = req_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  // When locked the grant is pinned to r_lock_id; the lane's own valid still
  // qualifies it so a dropped request cannot be forwarded.
  assign w_grant_vld = w_sel_valid;
  assign w_is_read   = (w_sel_wstrb == '0);
  // Decided on the registered count, so a same-cycle pop does not unblock.
  assign w_blocked   = w_is_read && (r_count == FULL_CNT);
  assign cache_valid = w_grant_vld && !w_blocked;
  assign cache_addr  = w_grant_vld ? w_sel_addr  : '0;
  assign cache_wdata = w_grant_vld ? w_sel_wdata : '0;
  assign cache_wstrb = w_grant_vld ? w_sel_wstrb : '0;
  assign w_xfer      = cache_valid && cache_ready;
  assign w_push      = w_xfer && w_is_read;
  assign w_pop       = cache_rvalid && (r_count != '0);

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_ready[i] = w_xfer && (w_grant_id == ID_W'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      r_last_grant <= ID_W'(N_REQ - 1);
      r_lock       <= 1'b0;
      r_lock_id    <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rsp_rvalid <= '0;
      r_rsp_rdata  <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      // A granted but unaccepted request (cache stall or FIFO full) keeps the lane.
      r_lock    <= w_grant_vld && !w_xfer;
      r_lock_id <= w_grant_id;
      if (w_xfer) begin
        r_last_grant <= w_grant_id;
      end
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_grant_id;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_rsp_rvalid <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (w_pop && (r_fifo[r_rd_ptr] == ID_W'(i))) begin
          r_rsp_rvalid[i]                   <= 1'b1;
          r_rsp_rdata[i*DATA_W +: DATA_W]   <= cache_rdata;
        end
      end
      if (cache_rvalid && (r_count == '0)) begin
        r_err_orphan <= 1'b1;
      end
    end
  end

  assign rsp_rvalid = r_rsp_rvalid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rd_pending = r_count;
  assign err_orphan = r_err_orphan;

endmodule
